// File: rtl/meta_merge_pkg.sv
// Shared types and helpers for the flow-table metadata merge block.
package meta_merge_pkg;

    // Source tag carried with every merged flit.
    typedef enum logic [1:0] {
        SRC_OUT = 2'd0,
        SRC_FWD = 2'd1,
        SRC_REO = 2'd2
    } meta_src_t;

    localparam int NUM_SRC = 3;

    // Round-robin successor of a source index (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/meta_fifo.sv
// Show-ahead FIFO: the head entry is visible on rdata while !empty, and a
// flit written in one cycle appears at the head in the next.
module meta_fifo #(
    parameter int W         = 512,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr,
    input  logic [W-1:0]               wdata,
    input  logic                       rd,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          af_q, af_d;
    logic          push, pop;

    // A full FIFO refuses the write even if a read frees a slot this cycle.
    assign full        = (occ_q == OW'(DEPTH));
    assign empty       = (occ_q == '0);
    assign push        = wr && !full;
    assign pop         = rd && !empty;
    assign rdata       = mem_q[rd_ptr_q];
    assign almost_full = af_q;
    assign occupancy   = occ_q;

    // Pointer/occupancy update; the threshold flag tracks the next occupancy
    // so it is registered in step with the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        occ_d    = occ_q + OW'(push) - OW'(pop);
        af_d     = (occ_d >= OW'(DEPTH - AF_MARGIN));
    end

    // Control state; storage is left unreset since pointers gate its use.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            af_q     <= af_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/meta_merge_avlstrm.sv
// Merges the out/forward/reorder metadata streams from the flow table into
// one tagged stream: per-source FIFOs, round-robin arbiter, one output
// register and per-stream flit counters.
module meta_merge_avlstrm
    import meta_merge_pkg::*;
#(
    parameter int META_W     = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [META_W-1:0] in_out_data,
    input  logic              in_out_valid,
    output logic              in_out_ready,
    output logic              in_out_almost_full,
    input  logic [META_W-1:0] in_fwd_data,
    input  logic              in_fwd_valid,
    output logic              in_fwd_ready,
    output logic              in_fwd_almost_full,
    input  logic [META_W-1:0] in_reo_data,
    input  logic              in_reo_valid,
    output logic              in_reo_ready,
    output logic              in_reo_almost_full,
    output logic [META_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       stats_in_out,
    output logic [31:0]       stats_in_fwd,
    output logic [31:0]       stats_in_reo,
    output logic [31:0]       stats_out
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_SRC-1:0]             in_valid, in_ready, push;
    logic [NUM_SRC-1:0]             fifo_empty, fifo_full, fifo_af, fifo_rd;
    logic [NUM_SRC-1:0][META_W-1:0] in_data, fifo_rdata;
    logic [NUM_SRC-1:0][OCC_W-1:0]  src_occ;
    logic [NUM_SRC-1:0][31:0]       stats_in;

    logic        load_en, gnt_valid;
    logic [1:0]  gnt_idx;
    logic [1:0]  rr_q, rr_d;
    logic        out_valid_q, out_valid_d;
    logic [META_W-1:0] out_data_q, out_data_d;
    meta_src_t   out_src_q, out_src_d;
    logic [31:0] stats_out_q, stats_out_d;

    assign in_valid = {in_reo_valid, in_fwd_valid, in_out_valid};
    assign in_data[0] = in_out_data;
    assign in_data[1] = in_fwd_data;
    assign in_data[2] = in_reo_data;

    // The output register accepts a new flit whenever it is empty or draining.
    assign load_en = !out_valid_q || out_ready;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [31:0] stats_q, stats_d;

            meta_fifo #(
                .W         (META_W),
                .DEPTH     (FIFO_DEPTH),
                .AF_MARGIN (AF_MARGIN)
            ) u_fifo (
                .clk         (Clk),
                .srst        (Rst),
                .wr          (push[gi]),
                .wdata       (in_data[gi]),
                .rd          (fifo_rd[gi]),
                .rdata       (fifo_rdata[gi]),
                .empty       (fifo_empty[gi]),
                .full        (fifo_full[gi]),
                .almost_full (fifo_af[gi]),
                .occupancy   (src_occ[gi])
            );

            assign in_ready[gi] = !fifo_full[gi] && !Rst;
            assign push[gi]     = in_valid[gi] && in_ready[gi];
            assign fifo_rd[gi]  = load_en && gnt_valid && (gnt_idx == 2'(gi));

            // Accepted-flit counter for this input, wrapping at 2^32.
            always_comb stats_d = stats_q + 32'(push[gi]);

            // Counter register.
            always_ff @(posedge Clk) begin
                if (Rst) stats_q <= '0;
                else     stats_q <= stats_d;
            end

            assign stats_in[gi] = stats_q;
        end
    endgenerate

    // Round-robin search over non-empty FIFOs starting at the pointer.
    always_comb begin
        logic [1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_valid && !fifo_empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
            cand = rr_next(cand);
        end
    end

    // Output register, pointer and delivered-flit counter next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_d        = rr_q;
        stats_out_d = stats_out_q + 32'(out_valid_q && out_ready);
        if (load_en) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = fifo_rdata[gnt_idx];
                out_src_d  = meta_src_t'(gnt_idx);
                rr_d       = rr_next(gnt_idx);
            end
        end
    end

    // Output stage and arbiter state registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_OUT;
            rr_q        <= 2'd0;
            stats_out_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_q        <= rr_d;
            stats_out_q <= stats_out_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_src            = out_src_q;
    assign in_out_ready       = in_ready[0];
    assign in_fwd_ready       = in_ready[1];
    assign in_reo_ready       = in_ready[2];
    assign in_out_almost_full = fifo_af[0];
    assign in_fwd_almost_full = fifo_af[1];
    assign in_reo_almost_full = fifo_af[2];
    assign stats_in_out       = stats_in[0];
    assign stats_in_fwd       = stats_in[1];
    assign stats_in_reo       = stats_in[2];
    assign stats_out          = stats_out_q;

    // Occupancy is kept only for debug observation.
    logic occ_debug_unused;
    assign occ_debug_unused = ^src_occ;

endmodule

// File: tb/tb_meta_merge_avlstrm.sv
// Directed bench for the metadata merge block: vector table plus hand-written
// multi-cycle sequences, all expectations computed by hand.
module tb_meta_merge_avlstrm;
    import meta_merge_pkg::*;

    localparam int META_W = 512;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [META_W-1:0] in_out_data, in_fwd_data, in_reo_data;
    logic              in_out_valid, in_fwd_valid, in_reo_valid;
    logic              in_out_ready, in_fwd_ready, in_reo_ready;
    logic              in_out_almost_full, in_fwd_almost_full, in_reo_almost_full;
    logic [META_W-1:0] out_data;
    logic [1:0]        out_src;
    logic              out_valid, out_ready;
    logic [31:0]       stats_in_out, stats_in_fwd, stats_in_reo, stats_out;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    meta_merge_avlstrm #(.META_W(META_W), .FIFO_DEPTH(16), .AF_MARGIN(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_out_data(in_out_data), .in_out_valid(in_out_valid),
        .in_out_ready(in_out_ready), .in_out_almost_full(in_out_almost_full),
        .in_fwd_data(in_fwd_data), .in_fwd_valid(in_fwd_valid),
        .in_fwd_ready(in_fwd_ready), .in_fwd_almost_full(in_fwd_almost_full),
        .in_reo_data(in_reo_data), .in_reo_valid(in_reo_valid),
        .in_reo_ready(in_reo_ready), .in_reo_almost_full(in_reo_almost_full),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready),
        .stats_in_out(stats_in_out), .stats_in_fwd(stats_in_fwd),
        .stats_in_reo(stats_in_reo), .stats_out(stats_out)
    );

    typedef struct {
        logic [2:0]  vld;      // {reo, fwd, out}
        logic [15:0] d_out;
        logic [15:0] d_fwd;
        logic [15:0] d_reo;
        logic        rdy;
        logic        e_vld;
        logic [1:0]  e_src;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [META_W-1:0] mk(input logic [15:0] v);
        logic [META_W-1:0] r;
        r = '0;
        r[15:0] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_out_valid = 1'b0; in_fwd_valid = 1'b0; in_reo_valid = 1'b0;
        in_out_data = '0; in_fwd_data = '0; in_reo_data = '0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, exp_next, fwd_seen;
        int cnt [3];

        // Single fwd flit, then a burst on all three with pointer at 2.
        tbl[0] = '{3'b010, 16'h0,  16'hA5, 16'h0,  1'b1, 1'b0, 2'd0, 16'h0};
        tbl[1] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b1, 2'd1, 16'hA5};
        tbl[2] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b0, 2'd0, 16'h0};
        tbl[3] = '{3'b111, 16'h10, 16'h11, 16'h12, 1'b1, 1'b0, 2'd0, 16'h0};
        tbl[4] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b1, 2'd2, 16'h12};
        tbl[5] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b1, 2'd0, 16'h10};
        tbl[6] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b1, 2'd1, 16'h11};
        tbl[7] = '{3'b000, 16'h0,  16'h0,  16'h0,  1'b1, 1'b0, 2'd0, 16'h0};

        // Reset state observed while Rst is still high.
        Rst = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data[63:0], 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_readys", 64'({in_out_ready, in_fwd_ready, in_reo_ready}), 64'd0);
        check("rst_stats", 64'(stats_in_out | stats_in_fwd | stats_in_reo | stats_out), 64'd0);
        Rst = 1'b0;
        #1;
        check("readys_after_rst", 64'({in_out_ready, in_fwd_ready, in_reo_ready}), 64'd7);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            in_out_valid = tbl[i].vld[0]; in_out_data = mk(tbl[i].d_out);
            in_fwd_valid = tbl[i].vld[1]; in_fwd_data = mk(tbl[i].d_fwd);
            in_reo_valid = tbl[i].vld[2]; in_reo_data = mk(tbl[i].d_reo);
            out_ready    = tbl[i].rdy;
            tick();
            $display("vec %0d: out_valid=%0b src=%0d data=%0h", i, out_valid, out_src, out_data[15:0]);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                check($sformatf("vec%0d_src", i), 64'(out_src), 64'(tbl[i].e_src));
                check($sformatf("vec%0d_data", i), out_data[63:0], 64'(tbl[i].e_data));
            end
        end
        check("vec_stats_out", 64'(stats_out), 64'd4);
        check("vec_stats_fwd", 64'(stats_in_fwd), 64'd2);

        // All three inputs valid every cycle for 30 cycles.
        do_reset();
        out_ready = 1'b1;
        in_out_valid = 1'b1; in_fwd_valid = 1'b1; in_reo_valid = 1'b1;
        for (int s = 0; s < 3; s++) cnt[s] = 0;
        for (int e = 0; e < 30; e++) begin
            in_out_data = mk(16'(e));
            in_fwd_data = mk(16'(256 + e));
            in_reo_data = mk(16'(512 + e));
            tick();
            if (e == 0) begin
                check("rr_fill", 64'(out_valid), 64'd0);
            end else begin
                check($sformatf("rr_valid%0d", e), 64'(out_valid), 64'd1);
                check($sformatf("rr_src%0d", e), 64'(out_src), 64'((e - 1) % 3));
                check($sformatf("rr_data%0d", e), out_data[63:0],
                      64'((((e - 1) % 3) * 256) + ((e - 1) / 3)));
                if (out_valid && out_src < 2'd3) cnt[out_src]++;
            end
        end
        check("rr_cnt_out", 64'(cnt[0]), 64'd10);
        check("rr_cnt_fwd", 64'(cnt[1]), 64'd10);
        check("rr_cnt_reo", 64'(cnt[2]), 64'd9);

        // Backpressure: output register held by a fwd flit, 20 offered on out.
        do_reset();
        in_fwd_valid = 1'b1; in_fwd_data = mk(16'hF0);
        tick();
        in_fwd_valid = 1'b0;
        tick();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            in_out_valid = 1'b1; in_out_data = mk(16'(i));
            tick();
            acc = (i + 1 < 16) ? i + 1 : 16;
            check($sformatf("bp_af%0d", i), 64'(in_out_almost_full), 64'(acc >= 12));
            check($sformatf("bp_ready%0d", i), 64'(in_out_ready), 64'(acc < 16));
            check($sformatf("bp_stats%0d", i), 64'(stats_in_out), 64'(acc));
            check($sformatf("bp_stable%0d", i), out_data[63:0], 64'h00F0);
        end
        in_out_valid = 1'b0;
        out_ready = 1'b1;
        exp_next = 0; fwd_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (out_src == 2'd1) begin
                    fwd_seen++;
                end else begin
                    check($sformatf("drain_data%0d", exp_next), out_data[63:0], 64'(exp_next));
                    exp_next++;
                end
            end
            tick();
        end
        check("drain_count", 64'(exp_next), 64'd16);
        check("drain_fwd", 64'(fwd_seen), 64'd1);
        check("drain_stats_in", 64'(stats_in_out), 64'd16);
        check("drain_stats_out", 64'(stats_out), 64'd17);
        check("drain_af", 64'(in_out_almost_full), 64'd0);

        // Full FIFO with pop and push offered together.
        do_reset();
        in_fwd_valid = 1'b1; in_fwd_data = mk(16'hF1);
        tick();
        in_fwd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_out_valid = 1'b1; in_out_data = mk(16'(i));
            tick();
        end
        check("full_occ", 64'(dut.src_occ[0]), 64'd16);
        check("full_ready", 64'(in_out_ready), 64'd0);
        out_ready = 1'b1; in_out_data = mk(16'd100);
        tick();
        check("pp_occA", 64'(dut.src_occ[0]), 64'd15);
        check("pp_statsA", 64'(stats_in_out), 64'd16);
        check("pp_readyA", 64'(in_out_ready), 64'd1);
        tick();
        check("pp_occB", 64'(dut.src_occ[0]), 64'd15);
        check("pp_statsB", 64'(stats_in_out), 64'd17);
        in_out_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("pp_occC", 64'(dut.src_occ[0]), 64'd15);
        in_out_valid = 1'b1;
        tick();
        check("pp_occD", 64'(dut.src_occ[0]), 64'd16);
        check("pp_readyD", 64'(in_out_ready), 64'd0);

        // Reset pulse with five reorder flits buffered.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_reo_valid = 1'b1; in_reo_data = mk(16'(16'h300 + i));
            tick();
        end
        in_reo_valid = 1'b0;
        check("rp_pre_valid", 64'(out_valid), 64'd1);
        check("rp_pre_stats", 64'(stats_in_reo), 64'd5);
        Rst = 1'b1;
        #1;
        check("rp_readys", 64'({in_out_ready, in_fwd_ready, in_reo_ready}), 64'd0);
        tick();
        Rst = 1'b0;
        check("rp_valid", 64'(out_valid), 64'd0);
        check("rp_stats", 64'(stats_in_out | stats_in_fwd | stats_in_reo | stats_out), 64'd0);
        check("rp_occ", 64'(dut.src_occ[2]), 64'd0);
        out_ready = 1'b1;
        in_fwd_valid = 1'b1; in_fwd_data = mk(16'h77);
        tick();
        in_fwd_valid = 1'b0;
        check("rp_lat1", 64'(out_valid), 64'd0);
        tick();
        check("rp_first_valid", 64'(out_valid), 64'd1);
        check("rp_first_src", 64'(out_src), 64'd1);
        check("rp_first_data", out_data[63:0], 64'h77);
        tick();
        check("rp_after1", 64'(out_valid), 64'd0);
        tick();
        check("rp_after2", 64'(out_valid), 64'd0);

        // stats_out wrap.
        do_reset();
        force dut.stats_out_q = 32'hFFFF_FFFE;
        #1;
        release dut.stats_out_q;
        #1;
        check("wrap_preload", 64'(stats_out), 64'hFFFF_FFFE);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_out_valid = 1'b1; in_out_data = mk(16'(i));
            tick();
        end
        in_out_valid = 1'b0;
        check("wrap_e2", 64'(stats_out), 64'hFFFF_FFFF);
        tick();
        check("wrap_e3", 64'(stats_out), 64'h0);
        tick();
        check("wrap_e4", 64'(stats_out), 64'h1);
        tick();
        check("wrap_final", 64'(stats_out), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
